gain_top: RTL
=============

# gain_top

Streaming volume/gain stage placed directly after the de-emphasis IIR (`iir_top`) on each audio channel. It accepts de-emphasised 32-bit signed samples through an input FIFO and multiplies each one by a fixed-point gain. It then dequantizes the product, applies the final output scaling shift, and delivers the result through an output FIFO to the audio sink. Both ends use the same FIFO write/read handshake as `iir_top`, so `iir_top.dout`/`out_empty` connect straight to this block's input side through a reader shim.

## Interface
- `DATA_WIDTH`, 32: sample width, signed two's complement.
- `FIFO_DEPTH`, 16: entries in each of the input and output FIFOs (power of two).
- `BITS`, 10: fixed-point fraction bits of `GAIN`.
- `GAIN`, 32'h0000_0400: signed gain, Q(BITS). The default is 1.0.
- `OUT_SHIFT`, 4: final left shift (14 − BITS).

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `din` in DATA_WIDTH: input sample; written when `in_wr_en`=1 and `in_full`=0.
- `in_wr_en` in 1: input FIFO write strobe.
- `in_full` out 1: input FIFO full.
- `dout` out DATA_WIDTH: head of output FIFO (show-ahead); valid while `out_empty`=0.
- `out_rd_en` in 1: pops the output FIFO head; ignored when `out_empty`=1.
- `out_empty` out 1: output FIFO empty.

## Operation
- Structure: input FIFO (show-ahead) → 2-stage core pipeline → output FIFO (show-ahead).
- Stage 1 (S1): when the input FIFO is not empty and the pipeline is not stalled, the block pops a sample and registers `prod = din * GAIN`. The product is 2·DATA_WIDTH bits signed, full precision.
- Stage 2 (S2): `q = prod / 2^BITS`, truncated toward zero (C division semantics, not a plain arithmetic shift). If `prod` < 0 and `prod[BITS-1:0]` ≠ 0, the shifted value is incremented by 1. The block then keeps the low DATA_WIDTH bits of q and computes `res = q << OUT_SHIFT`, wrapping modulo 2^DATA_WIDTH with no saturation.
- Output write: when S2 is valid and the output FIFO is not full, `res` is written to the output FIFO.
- Stall: if S2 is valid and the output FIFO is full, S1 and S2 both hold and no input pop occurs. Samples are never dropped or duplicated.
- Core FSM per stage: EMPTY / VALID, tracked by a valid bit. A stage advances when the downstream stage is free or advancing in the same cycle.
- FIFOs: simultaneous read and write in the same cycle are both honoured, and occupancy is unchanged. A write while full is ignored. A read while empty is ignored. Pointers wrap modulo FIFO_DEPTH, and full/empty are distinguished by an extra pointer bit.
- Reset values: `in_full`=0, `out_empty`=1, `dout`=0, and all valid bits, pointers and pipeline registers are 0.
- Reset mid-stream: all in-flight and buffered samples are discarded. The first output after reset corresponds to the first sample written after reset.

## Timing
- Latency: a sample written at edge k into an empty, idle path is popped by the core at edge k+1 and lands in S2 at edge k+2. It is written to the output FIFO at edge k+3, so `out_empty`=0 after edge k+3.
- Throughput: 1 sample/cycle sustained when `out_rd_en` is held high.
- `in_full` asserts the cycle after the FIFO_DEPTH-th unpopped word is written. It deasserts the cycle after a pop.
- `dout` changes only after an edge that pops or writes into the empty output FIFO.
- Maximum buffered samples before `in_full` with the output blocked: 2·FIFO_DEPTH + 2.

## Test plan
- Default params, `din` = 0x00000064 (100), 0x00000001, 0xFFFFFF9C (−100) → `dout` = 0x00000640, 0x00000010, 0xFFFFF9C0 in order; first `out_empty`=0 three edges after the first write.
- GAIN=32'h600 (1.5): `din` = 0xFFFFFFFD (−3) → 0xFFFFFFC0 (−4<<4, truncation toward zero). `din` = 0x00000003 → 0x00000040.
- Back-pressure: hold `out_rd_en`=0 and write 0,1,2,… until `in_full`=1. Exactly 34 words are accepted (default depth). Then drain and check `dout` = i<<4 for i=0..33 with no loss or duplication.
- Simultaneous: stream 100 words with `in_wr_en` and `out_rd_en` both high every cycle. Occupancy stays constant and all 100 outputs match.
- Reset mid-stream: assert `reset` asynchronously (between edges) after 10 writes. Outputs immediately go to `in_full`=0, `out_empty`=1, `dout`=0. Post-reset input 0x00000005 → first output 0x00000050.
- Golden file: feed `../data/left_deemph.txt` (100 words, `%08h`) and compare against the C-model gain output file. Required: 0 errors and a cycle count reported.

Source files
------------

// File: rtl/gain_top.sv
// gain_top: streaming fixed-point gain stage between show-ahead input and output FIFOs
module gain_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] din,
  input  logic         wr_en,
  output logic         full,
  output logic [W-1:0] head,
  input  logic         rd_en,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic we, re;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign we = wr_en & ~full;
  assign re = rd_en & ~empty;
  assign head = mem[rp[AW-1:0]];
  // pointers carry an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (we) wp <= wp + ONE;
      if (re) rp <= rp + ONE;
    end
  // storage needs no reset: the head is only consumed while non-empty
  always_ff @(posedge clock)
    if (we) mem[wp[AW-1:0]] <= din;
endmodule

module gain_top #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int BITS = 10,
  parameter logic [DATA_WIDTH-1:0] GAIN = 'h400,
  parameter int OUT_SHIFT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  in_wr_en,
  output logic                  in_full,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  out_rd_en,
  output logic                  out_empty
);
  localparam int W = DATA_WIDTH;
  logic [W-1:0] in_head, o_head, r2, res;
  logic in_empty, o_full, v1, v2, pop, adv, o_wr;
  logic signed [2*W-1:0] p1;
  logic [2*W-1:0] mul, sh;
  assign o_wr = v2 & ~o_full;
  assign adv = v1 & (~v2 | o_wr);
  assign pop = ~in_empty & (~v1 | adv);
  assign mul = {{W{in_head[W-1]}}, in_head} * {{W{GAIN[W-1]}}, GAIN};
  assign sh = p1 >>> BITS;
  assign res = (sh[W-1:0] + W'(p1[2*W-1] & |p1[BITS-1:0])) << OUT_SHIFT;
  assign dout = out_empty ? '0 : o_head;
  gain_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_in (
    .clock(clock), .reset(reset), .din(din), .wr_en(in_wr_en), .full(in_full),
    .head(in_head), .rd_en(pop), .empty(in_empty)
  );
  gain_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_out (
    .clock(clock), .reset(reset), .din(r2), .wr_en(o_wr), .full(o_full),
    .head(o_head), .rd_en(out_rd_en), .empty(out_empty)
  );
  // two-stage pipeline: S1 holds the full product, S2 the dequantized scaled result
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      p1 <= '0;
      r2 <= '0;
    end else begin
      if (~v1 | adv) begin
        v1 <= pop;
        if (pop) p1 <= mul;
      end
      if (~v2 | o_wr) begin
        v2 <= adv;
        if (adv) r2 <= res;
      end
    end
endmodule
